// File: rtl/time_display_if.sv
// Display bus between the timekeeper and the tube driver: time fields and
// adjust-mode flags flow toward the display, digit enables and segments flow out.
interface time_display_if;
    logic [5:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic       h;
    logic       min;
    logic [7:0] seg_en;
    logic [7:0] seg_out;

    modport master (
        output hour, minute, second, h, min,
        input  seg_en, seg_out
    );

    modport slave (
        input  hour, minute, second, h, min,
        output seg_en, seg_out
    );
endinterface

// File: rtl/time_display.sv
// Eight-digit multiplexed seven-segment driver rendering HH-MM-SS on a
// common-anode tube. One digit is lit at a time; each frame shows a single
// coherent snapshot of the time fields, and the field being adjusted blinks.
module time_display #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic          clk,
    input  logic          rst,
    time_display_if.slave disp
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    // Internal digit codes: 0..9 decimal, then the special glyphs.
    localparam logic [3:0] CODE_E     = 4'd10;
    localparam logic [3:0] CODE_DASH  = 4'd11;
    localparam logic [3:0] CODE_BLANK = 4'd12;

    // Tens digit by threshold counting, so no divider is needed.
    function automatic logic [3:0] tens_of(input logic [5:0] v);
        logic [3:0] t;
        t = 4'd0;
        if (v >= 6'd10) t = t + 4'd1;
        if (v >= 6'd20) t = t + 4'd1;
        if (v >= 6'd30) t = t + 4'd1;
        if (v >= 6'd40) t = t + 4'd1;
        if (v >= 6'd50) t = t + 4'd1;
        return t;
    endfunction

    function automatic logic [3:0] units_of(input logic [5:0] v);
        logic [5:0] t6;
        t6 = {2'b00, tens_of(v)};
        return 4'(v - t6 * 6'd10);
    endfunction

    // Out-of-range fields render as 'E' on both of their digits.
    function automatic logic [3:0] field_code(input logic [5:0] v,
                                              input logic [5:0] max_v,
                                              input logic       upper);
        if (v > max_v) return CODE_E;
        return upper ? tens_of(v) : units_of(v);
    endfunction

    function automatic logic [7:0] glyph(input logic [3:0] code);
        case (code)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            CODE_E:    return 8'h86;
            CODE_DASH: return 8'hBF;
            default: return 8'hFF;
        endcase
    endfunction

    logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
    logic [2:0]         idx_q,       idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q,     phase_d;
    logic               live_q,      live_d;
    logic [5:0]         snap_hour_q, snap_hour_d;
    logic [5:0]         snap_min_q,  snap_min_d;
    logic [5:0]         snap_sec_q,  snap_sec_d;
    logic               snap_h_q,    snap_h_d;
    logic               snap_m_q,    snap_m_d;
    logic [7:0]         seg_en_q,    seg_en_d;
    logic [7:0]         seg_out_q,   seg_out_d;

    logic scan_wrap;
    logic blink_wrap;
    logic frame_start;
    logic hour_blank;
    logic min_blank;
    logic [3:0] code;

    // Next-state for scan/blink counters, frame snapshot and output register.
    always_comb begin
        scan_cnt_d  = scan_cnt_q;
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        live_d      = 1'b1;
        snap_hour_d = snap_hour_q;
        snap_min_d  = snap_min_q;
        snap_sec_d  = snap_sec_q;
        snap_h_d    = snap_h_q;
        snap_m_d    = snap_m_q;
        code        = CODE_BLANK;

        // Scanning holds for the capture cycle after reset so digit 0 gets a full dwell.
        scan_wrap = live_q && (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        if (live_q) begin
            scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
        end
        if (scan_wrap) begin
            idx_d = idx_q + 3'd1;
        end

        blink_wrap  = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
        blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
        if (blink_wrap) begin
            phase_d = ~phase_q;
        end

        // Capture on the edge the index returns to 0 so the whole frame is coherent.
        frame_start = !live_q || (scan_wrap && (idx_q == 3'd7));
        if (frame_start) begin
            snap_hour_d = disp.hour;
            snap_min_d  = disp.minute;
            snap_sec_d  = disp.second;
            snap_h_d    = disp.h;
            snap_m_d    = disp.min;
        end

        hour_blank = !phase_q && snap_h_q;
        min_blank  = !phase_q && snap_m_q;

        case (idx_q)
            3'd7:    code = hour_blank ? CODE_BLANK : field_code(snap_hour_q, 6'd23, 1'b1);
            3'd6:    code = hour_blank ? CODE_BLANK : field_code(snap_hour_q, 6'd23, 1'b0);
            3'd5:    code = CODE_DASH;
            3'd4:    code = min_blank  ? CODE_BLANK : field_code(snap_min_q,  6'd59, 1'b1);
            3'd3:    code = min_blank  ? CODE_BLANK : field_code(snap_min_q,  6'd59, 1'b0);
            3'd2:    code = CODE_DASH;
            3'd1:    code = field_code(snap_sec_q, 6'd59, 1'b1);
            default: code = field_code(snap_sec_q, 6'd59, 1'b0);
        endcase

        // Enables and segments come from the same state and load on the same edge.
        seg_en_d  = live_q ? ~(8'b1 << idx_q) : 8'hFF;
        seg_out_d = live_q ? glyph(code)      : 8'hFF;
    end

    // State register; active-low synchronous reset returns everything to idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_cnt_q  <= '0;
            idx_q       <= 3'd0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
            live_q      <= 1'b0;
            snap_hour_q <= 6'd0;
            snap_min_q  <= 6'd0;
            snap_sec_q  <= 6'd0;
            snap_h_q    <= 1'b0;
            snap_m_q    <= 1'b0;
            seg_en_q    <= 8'hFF;
            seg_out_q   <= 8'hFF;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            live_q      <= live_d;
            snap_hour_q <= snap_hour_d;
            snap_min_q  <= snap_min_d;
            snap_sec_q  <= snap_sec_d;
            snap_h_q    <= snap_h_d;
            snap_m_q    <= snap_m_d;
            seg_en_q    <= seg_en_d;
            seg_out_q   <= seg_out_d;
        end
    end

    assign disp.seg_en  = seg_en_q;
    assign disp.seg_out = seg_out_q;

endmodule

// File: tb/tb_time_display.sv
// Bench for time_display: a cycle-level model derived from the display rules
// (frame timing, snapshot per frame, blink phase) checks every cycle, and
// directed literal expectations pin the model at key points.
module tb_time_display;

    localparam int SD = 4;
    localparam int BD = 64;
    localparam int HMAX = 8192;

    logic clk = 1'b0;
    logic rst;
    time_display_if ifc();

    time_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk  (clk),
        .rst  (rst),
        .disp (ifc)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n = 0;
    bit chk_en = 1'b0;

    int hist_hour [0:HMAX-1];
    int hist_min  [0:HMAX-1];
    int hist_sec  [0:HMAX-1];
    bit hist_h    [0:HMAX-1];
    bit hist_m    [0:HMAX-1];

    logic [7:0] DIGIT_GLYPH [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s n=%0d got=%h want=%h", name, n, got, want);
        end
    endtask

    function automatic logic [7:0] field_glyph(input int v, input int maxv, input bit upper);
        if (v > maxv) return 8'h86;
        return upper ? DIGIT_GLYPH[v / 10] : DIGIT_GLYPH[v % 10];
    endfunction

    // Expected outputs after the nn-th edge since reset release.
    task automatic model(input int nn, output logic [7:0] e_en, output logic [7:0] e_out);
        int t, d, ce;
        bit on;
        e_en  = 8'hFF;
        e_out = 8'hFF;
        if (nn >= 2) begin
            t  = nn - 2;
            d  = (t / SD) % 8;
            ce = 1 + 8 * SD * (t / (8 * SD));
            on = (((nn - 1) / BD) % 2) == 0;
            e_en = ~(8'b1 << d);
            case (d)
                7: e_out = (!on && hist_h[ce]) ? 8'hFF : field_glyph(hist_hour[ce], 23, 1'b1);
                6: e_out = (!on && hist_h[ce]) ? 8'hFF : field_glyph(hist_hour[ce], 23, 1'b0);
                5: e_out = 8'hBF;
                4: e_out = (!on && hist_m[ce]) ? 8'hFF : field_glyph(hist_min[ce], 59, 1'b1);
                3: e_out = (!on && hist_m[ce]) ? 8'hFF : field_glyph(hist_min[ce], 59, 1'b0);
                2: e_out = 8'hBF;
                1: e_out = field_glyph(hist_sec[ce], 59, 1'b1);
                default: e_out = field_glyph(hist_sec[ce], 59, 1'b0);
            endcase
        end
    endtask

    // Edge counter since release and record of the inputs sampled at each edge.
    always @(posedge clk) begin
        if (rst !== 1'b1) begin
            n = 0;
        end else begin
            n = n + 1;
            if (n < HMAX) begin
                hist_hour[n] = int'(ifc.hour);
                hist_min[n]  = int'(ifc.minute);
                hist_sec[n]  = int'(ifc.second);
                hist_h[n]    = ifc.h;
                hist_m[n]    = ifc.min;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [7:0] e_en, e_out;
        if (chk_en && n < HMAX) begin
            model(n, e_en, e_out);
            check("model_seg_en", ifc.seg_en, e_en);
            check("model_seg_out", ifc.seg_out, e_out);
        end
    end

    task automatic wait_n(input int target);
        int guard;
        guard = 0;
        while (n != target && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (n != target) begin
            checks++;
            errors++;
            $display("FAIL wait_n got=%0d want=%0d", n, target);
        end
    endtask

    logic [7:0] en_lit  [0:7] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] out_lit [0:7] = '{8'h90, 8'hC0, 8'hBF, 8'h92, 8'h99, 8'hBF, 8'hB0, 8'hF9};

    initial begin
        rst        = 1'b0;
        ifc.hour   = 6'd13;
        ifc.minute = 6'd45;
        ifc.second = 6'd9;
        ifc.h      = 1'b0;
        ifc.min    = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        // Reset held low
        for (int i = 0; i < 5; i++) begin
            check("rst_seg_en", ifc.seg_en, 8'hFF);
            check("rst_seg_out", ifc.seg_out, 8'hFF);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        wait_n(1);
        check("cap_edge_seg_en", ifc.seg_en, 8'hFF);
        wait_n(2);
        check("start_seg_en", ifc.seg_en, 8'hFE);
        check("start_seg_out", ifc.seg_out, 8'h90);

        // Static 13:45:09 frame
        for (int d = 0; d < 8; d++) begin
            wait_n(2 + SD * d);
            check("frame_seg_en", ifc.seg_en, en_lit[d]);
            check("frame_seg_out", ifc.seg_out, out_lit[d]);
        end

        // Snapshot coherence across a seconds rollover
        wait_n(30);
        ifc.second = 6'd59;
        wait_n(34);
        check("coh_s0_59", ifc.seg_out, 8'h90);
        wait_n(38);
        check("coh_s1_59", ifc.seg_out, 8'h92);
        wait_n(46);
        ifc.second = 6'd0;
        wait_n(66);
        check("coh_s0_00", ifc.seg_out, 8'hC0);
        wait_n(70);
        check("coh_s1_00", ifc.seg_out, 8'hC0);

        // Out-of-range fields
        wait_n(90);
        ifc.hour   = 6'd24;
        ifc.minute = 6'd63;
        ifc.second = 6'd0;
        wait_n(98);  check("oor_d0", ifc.seg_out, 8'hC0);
        wait_n(102); check("oor_d1", ifc.seg_out, 8'hC0);
        wait_n(110); check("oor_d3", ifc.seg_out, 8'h86);
        wait_n(114); check("oor_d4", ifc.seg_out, 8'h86);
        wait_n(118); check("oor_d5", ifc.seg_out, 8'hBF);
        wait_n(122); check("oor_d6", ifc.seg_out, 8'h86);
        wait_n(126); check("oor_d7", ifc.seg_out, 8'h86);

        // Hour blink
        wait_n(130);
        ifc.hour   = 6'd13;
        ifc.minute = 6'd45;
        ifc.second = 6'd9;
        ifc.h      = 1'b1;
        wait_n(194); check("blk_sec_on", ifc.seg_out, 8'h90);
        wait_n(218); check("blk_h6_off", ifc.seg_out, 8'hFF);
        wait_n(222);
        check("blk_h7_off", ifc.seg_out, 8'hFF);
        check("blk_h7_en", ifc.seg_en, 8'h7F);
        wait_n(286); check("blk_h7_on", ifc.seg_out, 8'hF9);

        // Hour and minute blink together
        wait_n(290);
        ifc.min = 1'b1;
        wait_n(334); check("blk_m3_off", ifc.seg_out, 8'hFF);
        wait_n(338);
        check("blk_m4_off", ifc.seg_out, 8'hFF);
        check("blk_m4_en", ifc.seg_en, 8'hEF);
        wait_n(350); check("blk_h7_off2", ifc.seg_out, 8'hFF);
        wait_n(398); check("blk_m3_on", ifc.seg_out, 8'h92);
        wait_n(402); check("blk_m4_on", ifc.seg_out, 8'h99);

        // Reset in the middle of digit 5
        wait_n(439);
        check("mid_before_en", ifc.seg_en, 8'hDF);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_en", ifc.seg_en, 8'hFF);
        check("mid_rst_out", ifc.seg_out, 8'hFF);
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_n(2);
        check("mid_restart_en", ifc.seg_en, 8'hFE);
        wait_n(6);
        check("mid_next_en", ifc.seg_en, 8'hFD);
        check("mid_next_out", ifc.seg_out, 8'hC0);
        wait_n(40);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
